// File: rtl/comparator_2bit_pkg.sv
// comparator_2bit_pkg: outcome indices and one-hot result type for the comparator
package comparator_2bit_pkg;
  localparam int CMP_GT = 0;
  localparam int CMP_LT = 1;
  localparam int CMP_EQ = 2;
  typedef logic [2:0] cmp_res_t;
endpackage

// File: rtl/comparator_2bit_core.sv
// comparator_2bit_core: combinational unsigned compare producing a one-hot gt/lt/eq result
module comparator_2bit_core
  import comparator_2bit_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);
  always_comb begin
    res         = '0;
    res[CMP_GT] = a > b;
    res[CMP_LT] = a < b;
    res[CMP_EQ] = a == b;
  end
endmodule

// File: rtl/comparator_2bit.sv
// comparator_2bit: registered unsigned comparator with saturating per-outcome counters
module comparator_2bit
  import comparator_2bit_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count
);
  cmp_res_t res;
  cmp_res_t flags;

  comparator_2bit_core #(.WIDTH(WIDTH)) u_core (.a(a), .b(b), .res(res));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction

  // A clear in the same cycle as a sample drops that sample from the counts
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      flags     <= '0;
      gt_count  <= '0;
      lt_count  <= '0;
      eq_count  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) flags <= res;
      if (cnt_clr) begin
        gt_count <= '0;
        lt_count <= '0;
        eq_count <= '0;
      end else if (in_valid) begin
        if (res[CMP_GT]) gt_count <= sat_inc(gt_count);
        if (res[CMP_LT]) lt_count <= sat_inc(lt_count);
        if (res[CMP_EQ]) eq_count <= sat_inc(eq_count);
      end
    end
  end

  assign a_gt_b = flags[CMP_GT];
  assign a_lt_b = flags[CMP_LT];
  assign a_eq_b = flags[CMP_EQ];
endmodule

// File: tb/tb_comparator_2bit.sv
// tb_comparator_2bit: scoreboard bench for the registered comparator and its counters
module tb_comparator_2bit;
  logic clk = 1'b0;
  logic rst, in_valid, cnt_clr;
  logic [1:0] a, b;
  logic ov, gt, lt, eq;
  logic [7:0] gc, lc, ec;
  logic ov2, gt2, lt2, eq2;
  logic [1:0] gc2, lc2, ec2;
  int compared = 0;
  int mismatched = 0;
  logic [2:0] sb[$];
  logic [2:0] exp_f;

  always #5 clk = ~clk;

  comparator_2bit #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(ov), .a_gt_b(gt), .a_lt_b(lt), .a_eq_b(eq),
    .gt_count(gc), .lt_count(lc), .eq_count(ec)
  );

  comparator_2bit #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(ov2), .a_gt_b(gt2), .a_lt_b(lt2), .a_eq_b(eq2),
    .gt_count(gc2), .lt_count(lc2), .eq_count(ec2)
  );

  function automatic logic [2:0] ref_flags(input logic [1:0] x, input logic [1:0] y);
    return {x > y, x < y, x == y};
  endfunction

  task automatic tick(input logic v, input logic [1:0] x, input logic [1:0] y, input logic clr, input logic r);
    rst = r; in_valid = v; a = x; b = y; cnt_clr = clr;
    if (r) sb.delete();
    else if (v) sb.push_back(ref_flags(x, y));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    tick(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 2'd3, 2'd0, 1'b0, 1'b1);
    tick(1'b1, 2'd3, 2'd0, 1'b1, 1'b1);
    compared++;
    if ({ov, gt, lt, eq} !== 4'b0000) begin
      mismatched++; $display("FAIL reset_flags: got ov/flags=%b want 0000", {ov, gt, lt, eq});
    end
    compared++;
    if ({gc, lc, ec} !== 24'd0 || {ov2, gc2, lc2, ec2} !== 7'd0) begin
      mismatched++; $display("FAIL reset_counts: got %0d/%0d/%0d ov2=%b c2=%0d/%0d/%0d want 0", gc, lc, ec, ov2, gc2, lc2, ec2);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] sa[6] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0};
    logic [1:0] sbv[6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
    logic [2:0] want[6] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, sa[i], sbv[i], 1'b0, 1'b0);
      compared++;
      if (ov !== 1'b1 || sb.size() == 0) begin
        mismatched++; $display("FAIL seq_valid[%0d]: got ov=%b q=%0d want ov=1", i, ov, sb.size());
      end else begin
        exp_f = sb.pop_front();
        compared++;
        if ({gt, lt, eq} !== exp_f || exp_f !== want[i]) begin
          mismatched++; $display("FAIL seq_flags[%0d]: got %b want %b", i, {gt, lt, eq}, want[i]);
        end
      end
    end
    compared++;
    if (gc !== 8'd2 || lc !== 8'd2 || ec !== 8'd2) begin
      mismatched++; $display("FAIL seq_counts: got %0d/%0d/%0d want 2/2/2", gc, lc, ec);
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    tick(1'b1, 2'd3, 2'd2, 1'b0, 1'b0);
    if (sb.size() != 0) exp_f = sb.pop_front();
    tick(1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    compared++;
    if ({ov, gt, lt, eq} !== 4'b0100) begin
      mismatched++; $display("FAIL drop_hold: got ov/flags=%b want 0100", {ov, gt, lt, eq});
    end
    compared++;
    if (gc !== 8'd1 || lc !== 8'd0 || ec !== 8'd0) begin
      mismatched++; $display("FAIL drop_counts: got %0d/%0d/%0d want 1/0/0", gc, lc, ec);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 2'(i % 4), 2'(i % 4), 1'b0, 1'b0);
      if (sb.size() != 0) exp_f = sb.pop_front();
    end
    compared++;
    if (ec2 !== 2'd3 || gc2 !== 2'd0 || lc2 !== 2'd0) begin
      mismatched++; $display("FAIL sat_counts: got eq=%0d gt=%0d lt=%0d want 3/0/0", ec2, gc2, lc2);
    end
    compared++;
    if (ec !== 8'd5) begin
      mismatched++; $display("FAIL sat_wide_eq: got %0d want 5", ec);
    end
  endtask

  task automatic test_clear();
    tick(1'b1, 2'd2, 2'd1, 1'b1, 1'b0);
    exp_f = (sb.size() != 0) ? sb.pop_front() : 3'b000;
    compared++;
    if ({ov, gt, lt, eq} !== {1'b1, exp_f}) begin
      mismatched++; $display("FAIL clr_flags: got ov/flags=%b want 1%b", {ov, gt, lt, eq}, exp_f);
    end
    compared++;
    if ({gc, lc, ec} !== 24'd0 || {gc2, lc2, ec2} !== 6'd0) begin
      mismatched++; $display("FAIL clr_counts: got %0d/%0d/%0d c2=%0d/%0d/%0d want 0", gc, lc, ec, gc2, lc2, ec2);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    if (sb.size() != 0) exp_f = sb.pop_front();
    tick(1'b1, 2'd0, 2'd1, 1'b0, 1'b1);
    compared++;
    if ({ov, gt, lt, eq} !== 4'b0000 || {gc, lc, ec} !== 24'd0) begin
      mismatched++; $display("FAIL midrst: got ov/flags=%b counts=%0d/%0d/%0d want 0000 0/0/0", {ov, gt, lt, eq}, gc, lc, ec);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rst = 1'b0; in_valid = 1'b1; a = 2'd3; b = 2'd0; cnt_clr = 1'b0;
    sb.push_back(ref_flags(2'd1, 2'd2));
    #2 a = 2'd0; b = 2'd3;
    @(negedge clk); a = 2'd1; b = 2'd2;
    @(posedge clk); #1;
    a = 2'd2; b = 2'd0; in_valid = 1'b0;
    #2;
    exp_f = (sb.size() != 0) ? sb.pop_front() : 3'b000;
    compared++;
    if ({ov, gt, lt, eq} !== {1'b1, exp_f}) begin
      mismatched++; $display("FAIL glitch: got ov/flags=%b want 1%b", {ov, gt, lt, eq}, exp_f);
    end
  endtask

  task automatic test_back_to_back_sweep();
    int ng = 0, nl = 0, ne = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 2'(i >> 2), 2'(i & 3), 1'b0, 1'b0);
      ng += (i >> 2) > (i & 3); nl += (i >> 2) < (i & 3); ne += (i >> 2) == (i & 3);
      compared++;
      if (ov !== 1'b1 || sb.size() == 0) begin
        mismatched++; $display("FAIL sweep_valid[%0d]: got ov=%b q=%0d want ov=1", i, ov, sb.size());
      end else begin
        exp_f = sb.pop_front();
        compared++;
        if ({gt, lt, eq} !== exp_f) begin
          mismatched++; $display("FAIL sweep_flags a=%0d b=%0d: got %b want %b", i >> 2, i & 3, {gt, lt, eq}, exp_f);
        end
      end
    end
    compared++;
    if (gc !== 8'(ng) || lc !== 8'(nl) || ec !== 8'(ne)) begin
      mismatched++; $display("FAIL sweep_counts: got %0d/%0d/%0d want %0d/%0d/%0d", gc, lc, ec, ng, nl, ne);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; a = '0; b = '0;
    test_reset();
    test_sequence();
    test_drop_valid();
    test_saturate();
    test_clear();
    test_mid_reset();
    test_glitch();
    test_back_to_back_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
